// File: rtl/tdc_link_pkg.sv
// Shared definitions for the TDC host link: sync byte, FSM encodings, frame
// byte positions and the host command characters.
package tdc_link_pkg;

   localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

   localparam logic [1:0] ENC_IDLE = 2'd0;
   localparam logic [1:0] ENC_SEND = 2'd1;
   localparam logic [1:0] ENC_GAP  = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ENC_IDLE,
      SEND = ENC_SEND,
      GAP  = ENC_GAP
   } tx_state_t;

   localparam int IDX_SYNC  = 0;
   localparam int IDX_CH    = 1;
   localparam int IDX_DATA0 = 2;

   // Characters decoded on the host command path
   localparam logic [7:0] CMD_START  = 8'h53;  // 'S'
   localparam logic [7:0] CMD_PAUSE  = 8'h50;  // 'P'
   localparam logic [7:0] CMD_RESUME = 8'h52;  // 'R'
   localparam logic [7:0] CMD_STATUS = 8'h3F;  // '?'

endpackage

// File: rtl/tdc_frame_tx.sv
// Serialises one TDC measurement into a SYNC/CH/DATA[/checksum] byte frame
// for uart_tx. Define TX_CHECKSUM_EN to append the XOR checksum byte.
//
// state | meaning
// IDLE  | waiting for an unpaused measurement
// SEND  | waiting for uart_tx idle, then loading frame[byte_idx]
// GAP   | one cycle for uart_tx busy to assert; advance or finish frame
module tdc_frame_tx
   import tdc_link_pkg::*;
#(
   parameter int          CH_W      = 3,
   parameter int          DATA_W    = 24,
   parameter logic [7:0]  SYNC_BYTE = DEF_SYNC_BYTE
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              meas_valid,
   input  logic [CH_W-1:0]   meas_ch,
   input  logic [DATA_W-1:0] meas_data,
   input  logic              pause,
   input  logic              tx_busy,
   output logic [7:0]        tx_data,
   output logic              new_tx_data,
   output logic              busy,
   output logic [15:0]       frames_sent,
   output logic [7:0]        drop_cnt
);

   localparam int NB = DATA_W / 8;
`ifdef TX_CHECKSUM_EN
   localparam int LAST_I = NB + 2;
`else
   localparam int LAST_I = NB + 1;
`endif
   localparam int IDX_W = $clog2(LAST_I + 1);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(LAST_I);

   tx_state_t         state, state_nxt;
   logic [IDX_W-1:0]  byte_idx;
   logic [CH_W-1:0]   lat_ch;
   logic [DATA_W-1:0] lat_data;
   logic [7:0]        cur_byte;
`ifdef TX_CHECKSUM_EN
   logic [7:0]        csum;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (meas_valid && !pause) state_nxt = SEND;
         SEND:    if (!tx_busy) state_nxt = GAP;
         GAP:     state_nxt = (byte_idx == LAST) ? IDLE : SEND;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
`ifdef TX_CHECKSUM_EN
      csum = 8'(lat_ch);
      for (int i = 0; i < NB; i++) csum = csum ^ lat_data[8*i +: 8];
      cur_byte = csum;
`else
      cur_byte = 8'h00;
`endif
      if (byte_idx == IDX_W'(IDX_SYNC))
         cur_byte = SYNC_BYTE;
      else if (byte_idx == IDX_W'(IDX_CH))
         cur_byte = 8'(lat_ch);
      else
         for (int i = 0; i < NB; i++)
            if (byte_idx == IDX_W'(IDX_DATA0 + i))
               cur_byte = lat_data[DATA_W-1-8*i -: 8];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_data     <= 8'h00;
         new_tx_data <= 1'b0;
         busy        <= 1'b0;
         frames_sent <= 16'h0000;
         drop_cnt    <= 8'h00;
         byte_idx    <= '0;
         lat_ch      <= '0;
         lat_data    <= '0;
      end else begin
         new_tx_data <= 1'b0;
         case (state)
            IDLE: begin
               if (meas_valid && !pause) begin
                  lat_ch   <= meas_ch;
                  lat_data <= meas_data;
                  byte_idx <= '0;
                  busy     <= 1'b1;
               end
            end
            SEND: begin
               if (!tx_busy) begin
                  new_tx_data <= 1'b1;
                  tx_data     <= cur_byte;
               end
            end
            GAP: begin
               if (byte_idx == LAST) begin
                  frames_sent <= frames_sent + 16'd1;
                  busy        <= 1'b0;
               end else begin
                  byte_idx <= byte_idx + 1'b1;
               end
            end
            default: ;
         endcase
         // busy covers SEND and GAP, including the final GAP cycle
         if (meas_valid && busy && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
      end
   end

endmodule
